// File: rtl/id_ex_decode_pkg.sv
// Shared encodings for the ID-stage decoder: ALU op codes (must match the
// EX-stage ALU), MIPS opcode/funct values, ALUSrcA encodings and the decoded
// control bundle carried into the ID/EX register.
package id_ex_decode_pkg;

  // ALU operation codes
  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_AND  = 5'd1;
  localparam logic [4:0] ALU_XOR  = 5'd2;
  localparam logic [4:0] ALU_OR   = 5'd3;
  localparam logic [4:0] ALU_NOR  = 5'd4;
  localparam logic [4:0] ALU_SUB  = 5'd5;
  localparam logic [4:0] ALU_ANDI = 5'd6;
  localparam logic [4:0] ALU_XORI = 5'd7;
  localparam logic [4:0] ALU_ORI  = 5'd8;
  localparam logic [4:0] ALU_JR   = 5'd9;
  localparam logic [4:0] ALU_BEQ  = 5'd10;
  localparam logic [4:0] ALU_BNE  = 5'd11;
  localparam logic [4:0] ALU_BGEZ = 5'd12;
  localparam logic [4:0] ALU_BGTZ = 5'd13;
  localparam logic [4:0] ALU_BLEZ = 5'd14;
  localparam logic [4:0] ALU_BLTZ = 5'd15;
  localparam logic [4:0] ALU_SLL  = 5'd16;
  localparam logic [4:0] ALU_SRL  = 5'd17;
  localparam logic [4:0] ALU_SRA  = 5'd18;
  localparam logic [4:0] ALU_SLT  = 5'd19;
  localparam logic [4:0] ALU_SLTU = 5'd20;

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_BLEZ   = 6'h06;
  localparam logic [5:0] OP_BGTZ   = 6'h07;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_ADDIU  = 6'h09;
  localparam logic [5:0] OP_SLTI   = 6'h0A;
  localparam logic [5:0] OP_SLTIU  = 6'h0B;
  localparam logic [5:0] OP_ANDI   = 6'h0C;
  localparam logic [5:0] OP_ORI    = 6'h0D;
  localparam logic [5:0] OP_XORI   = 6'h0E;
  localparam logic [5:0] OP_LUI    = 6'h0F;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_SW     = 6'h2B;

  // R-type funct codes
  localparam logic [5:0] FUNCT_SLL  = 6'h00;
  localparam logic [5:0] FUNCT_SRL  = 6'h02;
  localparam logic [5:0] FUNCT_SRA  = 6'h03;
  localparam logic [5:0] FUNCT_SLLV = 6'h04;
  localparam logic [5:0] FUNCT_SRLV = 6'h06;
  localparam logic [5:0] FUNCT_SRAV = 6'h07;
  localparam logic [5:0] FUNCT_JR   = 6'h08;
  localparam logic [5:0] FUNCT_ADD  = 6'h20;
  localparam logic [5:0] FUNCT_ADDU = 6'h21;
  localparam logic [5:0] FUNCT_SUB  = 6'h22;
  localparam logic [5:0] FUNCT_SUBU = 6'h23;
  localparam logic [5:0] FUNCT_AND  = 6'h24;
  localparam logic [5:0] FUNCT_OR   = 6'h25;
  localparam logic [5:0] FUNCT_XOR  = 6'h26;
  localparam logic [5:0] FUNCT_NOR  = 6'h27;
  localparam logic [5:0] FUNCT_SLT  = 6'h2A;
  localparam logic [5:0] FUNCT_SLTU = 6'h2B;

  // REGIMM rt selectors
  localparam logic [4:0] RT_BLTZ = 5'd0;
  localparam logic [4:0] RT_BGEZ = 5'd1;

  // ALUSrcA encodings
  localparam logic [1:0] SRCA_RS    = 2'b00;
  localparam logic [1:0] SRCA_SHAMT = 2'b01;
  localparam logic [1:0] SRCA_ZERO  = 2'b10;

  // Decoded controls for one instruction; all-zero is a bubble.
  typedef struct packed {
    logic [4:0]  alu_code;
    logic [1:0]  src_a;
    logic        src_b;
    logic [31:0] imm32;
    logic [4:0]  write_reg;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        jump;
    logic        illegal;
  } ctrl_t;

endpackage

// File: rtl/id_ex_decode_decode.sv
// Pure combinational MIPS instruction decoder: instruction word in,
// control bundle out, plus whether the rt field is read as a source.
module decode_comb
  import id_ex_decode_pkg::*;
#(
  parameter logic [4:0] LINK_REG = 5'd31
) (
  input  logic [31:0] instr,
  output ctrl_t       ctrl,
  output logic        uses_rt
);

  logic [5:0]  op;
  logic [5:0]  funct;
  logic [15:0] imm;

  assign op    = instr[31:26];
  assign funct = instr[5:0];
  assign imm   = instr[15:0];

  // Map opcode/funct to ALU op, operand selects and pipeline controls.
  always_comb begin
    // NOTE: every field gets a default first so no path leaves a latch.
    ctrl           = '0;
    ctrl.alu_code  = ALU_ADD;
    ctrl.src_a     = SRCA_RS;
    ctrl.imm32     = {{16{imm[15]}}, imm};
    ctrl.rs        = instr[25:21];
    ctrl.rt        = instr[20:16];
    ctrl.write_reg = instr[20:16];
    uses_rt        = 1'b0;

    case (op)
      OP_RTYPE: begin
        uses_rt        = 1'b1;
        ctrl.write_reg = instr[15:11];
        ctrl.reg_write = 1'b1;
        case (funct)
          FUNCT_ADD, FUNCT_ADDU: ctrl.alu_code = ALU_ADD;
          FUNCT_SUB, FUNCT_SUBU: ctrl.alu_code = ALU_SUB;
          FUNCT_AND:  ctrl.alu_code = ALU_AND;
          FUNCT_OR:   ctrl.alu_code = ALU_OR;
          FUNCT_XOR:  ctrl.alu_code = ALU_XOR;
          FUNCT_NOR:  ctrl.alu_code = ALU_NOR;
          FUNCT_SLT:  ctrl.alu_code = ALU_SLT;
          FUNCT_SLTU: ctrl.alu_code = ALU_SLTU;
          FUNCT_SLL:  begin ctrl.alu_code = ALU_SLL; ctrl.src_a = SRCA_SHAMT; end
          FUNCT_SRL:  begin ctrl.alu_code = ALU_SRL; ctrl.src_a = SRCA_SHAMT; end
          FUNCT_SRA:  begin ctrl.alu_code = ALU_SRA; ctrl.src_a = SRCA_SHAMT; end
          FUNCT_SLLV: ctrl.alu_code = ALU_SLL;
          FUNCT_SRLV: ctrl.alu_code = ALU_SRL;
          FUNCT_SRAV: ctrl.alu_code = ALU_SRA;
          FUNCT_JR: begin
            ctrl.alu_code  = ALU_JR;
            ctrl.jump      = 1'b1;
            ctrl.reg_write = 1'b0;
          end
          default: ctrl.illegal = 1'b1;
        endcase
      end
      OP_ADDI, OP_ADDIU: begin ctrl.src_b = 1'b1; ctrl.reg_write = 1'b1; end
      OP_SLTI:  begin ctrl.alu_code = ALU_SLT;  ctrl.src_b = 1'b1; ctrl.reg_write = 1'b1; end
      OP_SLTIU: begin ctrl.alu_code = ALU_SLTU; ctrl.src_b = 1'b1; ctrl.reg_write = 1'b1; end
      OP_ANDI, OP_ORI, OP_XORI: begin
        ctrl.alu_code  = (op == OP_ANDI) ? ALU_ANDI : (op == OP_ORI) ? ALU_ORI : ALU_XORI;
        ctrl.src_b     = 1'b1;
        ctrl.imm32     = {16'h0000, imm};
        ctrl.reg_write = 1'b1;
      end
      OP_LUI: begin
        ctrl.src_a     = SRCA_ZERO;
        ctrl.src_b     = 1'b1;
        ctrl.imm32     = {imm, 16'h0000};
        ctrl.reg_write = 1'b1;
      end
      OP_LW: begin ctrl.src_b = 1'b1; ctrl.reg_write = 1'b1; ctrl.mem_read = 1'b1; end
      OP_SW: begin ctrl.src_b = 1'b1; ctrl.mem_write = 1'b1; uses_rt = 1'b1; end
      OP_BEQ:  begin ctrl.alu_code = ALU_BEQ;  ctrl.branch = 1'b1; uses_rt = 1'b1; end
      OP_BNE:  begin ctrl.alu_code = ALU_BNE;  ctrl.branch = 1'b1; uses_rt = 1'b1; end
      OP_BLEZ: begin ctrl.alu_code = ALU_BLEZ; ctrl.branch = 1'b1; end
      OP_BGTZ: begin ctrl.alu_code = ALU_BGTZ; ctrl.branch = 1'b1; end
      OP_REGIMM: begin
        ctrl.branch = 1'b1;
        if (instr[20:16] == RT_BLTZ)      ctrl.alu_code = ALU_BLTZ;
        else if (instr[20:16] == RT_BGEZ) ctrl.alu_code = ALU_BGEZ;
        else                              ctrl.illegal  = 1'b1;
      end
      OP_J: ctrl.jump = 1'b1;
      OP_JAL: begin
        ctrl.jump      = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.write_reg = LINK_REG;
        ctrl.src_a     = SRCA_ZERO;
      end
      default: ctrl.illegal = 1'b1;
    endcase

    // Writes to $0 are discarded at the source.
    if (ctrl.write_reg == 5'd0) ctrl.reg_write = 1'b0;
  end

endmodule

// File: rtl/id_ex_decode.sv
// ID/EX pipeline register with load-use hazard detection. Decoding is done
// by decode_comb; this level owns the register, its update priority and the
// stall request toward PC and IF/ID.
module id_ex_decode
  import id_ex_decode_pkg::*;
#(
  parameter logic [4:0] LINK_REG   = 5'd31,
  parameter bit         EN_LOADUSE = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] id_instr,
  input  logic        id_valid,
  input  logic        ex_stall,
  input  logic        flush,
  output logic        stall_req,
  output logic [4:0]  ALUCode,
  output logic [1:0]  ALUSrcA,
  output logic        ALUSrcB,
  output logic [31:0] Imm32,
  output logic [4:0]  WriteReg,
  output logic [4:0]  ex_rs,
  output logic [4:0]  ex_rt,
  output logic        RegWrite,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        Branch,
  output logic        Jump,
  output logic        ex_valid,
  output logic        illegal
);

  ctrl_t dec;
  logic  dec_uses_rt;
  ctrl_t q;
  logic  valid_q;

  decode_comb #(.LINK_REG(LINK_REG)) u_decode (
    .instr   (id_instr),
    .ctrl    (dec),
    .uses_rt (dec_uses_rt)
  );

  // Load-use hazard: the held lw targets a register the incoming instruction reads.
  assign stall_req = EN_LOADUSE && id_valid && valid_q && q.mem_read && (q.rt != 5'd0) &&
                     ((q.rt == dec.rs) || (dec_uses_rt && (q.rt == dec.rt)));

  // ID/EX register: flush > hold > load-use bubble > idle bubble > decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so all flops sample together.
      q       <= '0;
      valid_q <= 1'b0;
    end else if (flush) begin
      q       <= '0;
      valid_q <= 1'b0;
    end else if (ex_stall) begin
      q       <= q;
      valid_q <= valid_q;
    end else if (stall_req || !id_valid) begin
      q       <= '0;
      valid_q <= 1'b0;
    end else if (dec.illegal) begin
      q         <= '0;
      q.illegal <= 1'b1;
      valid_q   <= 1'b0;
    end else begin
      q       <= dec;
      valid_q <= 1'b1;
    end
  end

  assign ALUCode  = q.alu_code;
  assign ALUSrcA  = q.src_a;
  assign ALUSrcB  = q.src_b;
  assign Imm32    = q.imm32;
  assign WriteReg = q.write_reg;
  assign ex_rs    = q.rs;
  assign ex_rt    = q.rt;
  assign RegWrite = q.reg_write;
  assign MemRead  = q.mem_read;
  assign MemWrite = q.mem_write;
  assign Branch   = q.branch;
  assign Jump     = q.jump;
  assign ex_valid = valid_q;
  assign illegal  = q.illegal;

endmodule
